// File: rtl/fp_normpack_if.sv
// fp_normpack_if: start/done handshake plus operand and result bus of the
// FP normalize/round/pack back end. The master side drives the unpacked sum,
// the slave side (fp_normpack) returns the packed single and status flags.
interface fp_normpack_if #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 10
);
  logic                    norm_start;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [MANT_W-1:0]       in_mant;
  logic [31:0]             norm_result;
  logic                    norm_done;
  logic                    norm_busy;
  logic                    norm_overflow;
  logic                    norm_underflow;
  logic                    norm_inexact;

  modport master (
    output norm_start, in_sign, in_exp, in_mant,
    input  norm_result, norm_done, norm_busy,
    input  norm_overflow, norm_underflow, norm_inexact
  );

  modport slave (
    input  norm_start, in_sign, in_exp, in_mant,
    output norm_result, norm_done, norm_busy,
    output norm_overflow, norm_underflow, norm_inexact
  );
endinterface

// File: rtl/fp_normpack.sv
// fp_normpack: normalizes, rounds (nearest, ties to even) and packs the
// unpacked sum from the add/sub aligner into an IEEE-754 single.
// Normalization moves one bit per cycle under a small FSM.
// Mantissa layout: [27]=carry, [26]=hidden, [25:3]=fraction, [2:0]=G/R/S.
// Optional feature macro: FP_DENORM_EN -- when defined, tiny results are
// delivered as denormals; otherwise they flush to signed zero.
module fp_normpack #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 10
) (
  input logic          clk,
  input logic          rst,
  fp_normpack_if.slave bus
);

`ifdef FP_DENORM_EN
  localparam bit DENORM_EN = 1'b1;
`else
  localparam bit DENORM_EN = 1'b0;
`endif

  localparam int HID = MANT_W - 2;
  localparam int CRY = MANT_W - 1;
  localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'(255);

  typedef enum logic [2:0] {IDLE, CHECK, NORM, ROUND, PACK} state_t;

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic                    rnd_inexact_q, rnd_inexact_d;
  logic [31:0]             result_q, result_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    inx_q, inx_d;

  logic [MANT_W-1:0]       mant_rsh;
  logic [MANT_W-1:0]       mant_lsh;
  logic signed [EXP_W-1:0] exp_inc;
  logic signed [EXP_W-1:0] exp_dec;
  logic                    rnd_up;
  logic [MANT_W-4:0]       rnd_sum;
  logic                    tiny;
  logic                    flush;

  // Single-bit shifts of the working mantissa; right shift keeps the lost
  // bit alive in the sticky position so rounding still sees it.
  assign mant_rsh = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
  assign mant_lsh = {mant_q[MANT_W-2:0], 1'b0};
  assign exp_inc  = exp_q + EXP_ONE;
  assign exp_dec  = exp_q - EXP_ONE;

  // Round to nearest even: bump the fraction when G is set and either R/S
  // is set or the fraction LSB is odd.
  assign rnd_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign rnd_sum = mant_q[MANT_W-1:3] + (MANT_W-3)'(rnd_up);

  // Next-state and next-output logic for the normalize/round/pack sequence.
  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    mant_d        = mant_q;
    rnd_inexact_d = rnd_inexact_q;
    result_d      = result_q;
    done_d        = 1'b0;
    busy_d        = busy_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    inx_d         = inx_q;
    tiny          = 1'b0;
    flush         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.norm_start) begin
          sign_d  = bus.in_sign;
          exp_d   = bus.in_exp;
          mant_d  = bus.in_mant;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (mant_q == '0) begin
          result_d = {sign_q, 31'b0};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          if (mant_q[CRY]) begin
            mant_d = mant_rsh;
            exp_d  = exp_inc;
            tiny   = (exp_inc < EXP_ONE);
          end else begin
            tiny = (exp_q < EXP_ONE) || (!mant_q[HID] && (exp_q == EXP_ONE));
          end
          if (tiny) begin
            if (DENORM_EN) state_d = (exp_d < EXP_ONE) ? NORM : ROUND;
            else           flush   = 1'b1;
          end else if (mant_q[CRY] || mant_q[HID]) begin
            state_d = ROUND;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (DENORM_EN && (exp_q < EXP_ONE)) begin
          mant_d = mant_rsh;
          exp_d  = exp_inc;
          if (exp_inc == EXP_ONE) state_d = ROUND;
        end else begin
          mant_d = mant_lsh;
          exp_d  = exp_dec;
          if (mant_lsh[HID]) begin
            state_d = ROUND;
          end else if (exp_dec == EXP_ONE) begin
            if (DENORM_EN) state_d = ROUND;
            else           flush   = 1'b1;
          end
        end
      end

      ROUND: begin
        rnd_inexact_d = |mant_q[2:0];
        if (rnd_sum[MANT_W-4]) begin
          mant_d = {1'b0, rnd_sum, 2'b00};
          exp_d  = exp_inc;
        end else begin
          mant_d = {rnd_sum, 3'b000};
        end
        state_d = PACK;
      end

      PACK: begin
        inx_d   = rnd_inexact_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (exp_q >= EXP_INF) begin
          result_d = {sign_q, 8'hFF, 23'b0};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
        end else if (mant_q[HID]) begin
          result_d = {sign_q, exp_q[7:0], mant_q[HID-1:3]};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else begin
          result_d = {sign_q, 8'h00, mant_q[HID-1:3]};
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (flush) begin
      result_d = {sign_q, 31'b0};
      ovf_d    = 1'b0;
      unf_d    = 1'b1;
      inx_d    = 1'b1;
      done_d   = 1'b1;
      busy_d   = 1'b0;
      state_d  = IDLE;
    end
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
      rnd_inexact_q <= 1'b0;
      result_q      <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      inx_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      mant_q        <= mant_d;
      rnd_inexact_q <= rnd_inexact_d;
      result_q      <= result_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      inx_q         <= inx_d;
    end
  end

  assign bus.norm_result    = result_q;
  assign bus.norm_done      = done_q;
  assign bus.norm_busy      = busy_q;
  assign bus.norm_overflow  = ovf_q;
  assign bus.norm_underflow = unf_q;
  assign bus.norm_inexact   = inx_q;

endmodule

// File: tb/tb_fp_normpack.sv
// tb_fp_normpack: directed and random checks of fp_normpack against an
// arithmetic reference model. Honours FP_DENORM_EN like the design.
module tb_fp_normpack;

`ifdef FP_DENORM_EN
  localparam bit DENORM = 1'b1;
`else
  localparam bit DENORM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  fp_normpack_if #(.MANT_W(28), .EXP_W(10)) bus ();

  fp_normpack #(.MANT_W(28), .EXP_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Hard stop in case the whole sequence wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: locate the leading one, pick the final exponent (clamped to
  // 1 for denormals), rescale with one exact shift, then round and pack.
  function automatic void refModel(input logic s, input int e, input logic [27:0] m,
                                   output logic [31:0] res, output logic ovf,
                                   output logic unf, output logic inx, output int lat);
    int          p, en, eb, k;
    logic [63:0] w, lost;
    logic [24:0] f;
    logic        inc;
    ovf = 1'b0; unf = 1'b0; inx = 1'b0; lat = -1;
    if (m == 28'd0) begin
      res = {s, 31'b0};
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    en = e + p - 26;
    if (en < 1 && !DENORM) begin
      res = {s, 31'b0};
      unf = 1'b1;
      inx = 1'b1;
      return;
    end
    if (en >= 1) lat = (p == 27) ? 3 : 3 + (26 - p);
    eb = (en < 1) ? 1 : en;
    k  = e - eb;
    w  = {36'b0, m};
    if (k >= 0) begin
      w = w << k;
    end else begin
      k = -k;
      if (k > 40) k = 40;
      lost = w & ((64'd1 << k) - 64'd1);
      w    = (w >> k) | {63'b0, |lost};
    end
    inx = |w[2:0];
    inc = w[2] & (w[1] | w[0] | w[3]);
    f   = w[27:3] + {24'b0, inc};
    if (f[24]) begin
      f  = f >> 1;
      eb = eb + 1;
    end
    if (eb >= 255) begin
      res = {s, 8'hFF, 23'b0};
      ovf = 1'b1;
    end else if (f[23]) begin
      res = {s, eb[7:0], f[22:0]};
    end else begin
      res = {s, 8'h00, f[22:0]};
      unf = 1'b1;
    end
  endfunction

  // Waits (bounded) for norm_done; n counts edges since the capture edge.
  task automatic waitDone(inout int n, output bit seen);
    while (n <= 300 && bus.norm_done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    seen = (bus.norm_done === 1'b1);
  endtask

  // Issues one operation, waits for its done pulse and checks everything.
  task automatic applyStimulus(input string tag, input logic s, input int e,
                               input logic [27:0] m, input bit same_cycle);
    logic [31:0] er;
    logic        eo, eu, ei;
    int          el, n;
    bit          seen;
    refModel(s, e, m, er, eo, eu, ei, el);
    if (!same_cycle) @(negedge clk);
    bus.norm_start = 1'b1;
    bus.in_sign    = s;
    bus.in_exp     = 10'(e);
    bus.in_mant    = m;
    @(posedge clk);
    @(negedge clk);
    bus.norm_start = 1'b0;
    n = 0;
    checkOutput({tag, ".busy_after_capture"}, {31'b0, bus.norm_busy}, 32'd1);
    waitDone(n, seen);
    checkOutput({tag, ".done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      checkOutput({tag, ".result"}, bus.norm_result, er);
      checkOutput({tag, ".flags"},
                  {29'b0, bus.norm_overflow, bus.norm_underflow, bus.norm_inexact},
                  {29'b0, eo, eu, ei});
      checkOutput({tag, ".busy_in_done"}, {31'b0, bus.norm_busy}, 32'd0);
      if (el >= 0) checkOutput({tag, ".latency"}, 32'(n), 32'(el));
    end
  endtask

  initial begin
    logic [31:0] er;
    logic        eo, eu, ei;
    int          el, n, cnt;
    bit          seen;
    logic [27:0] m, mask;
    int          e, nb;
    logic        s;

    rst            = 1'b1;
    bus.norm_start = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_exp     = '0;
    bus.in_mant    = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_result", bus.norm_result, 32'd0);
    checkOutput("reset_outputs",
                {27'b0, bus.norm_done, bus.norm_busy, bus.norm_overflow,
                 bus.norm_underflow, bus.norm_inexact}, 32'd0);
    rst = 1'b0;

    applyStimulus("sum_1p25_1p5", 1'b0, 127, 28'hB000000, 1'b0);
    @(negedge clk);
    checkOutput("done_is_pulse", {31'b0, bus.norm_done}, 32'd0);
    applyStimulus("diff_1p5_1p25", 1'b0, 127, 28'h1000000, 1'b0);
    applyStimulus("zero_neg", 1'b1, 127, 28'h0000000, 1'b0);
    applyStimulus("tie_even", 1'b0, 127, 28'h4000004, 1'b0);
    applyStimulus("tie_odd_b2b", 1'b0, 127, 28'h400000C, 1'b1);
    applyStimulus("round_carry", 1'b1, 127, 28'h7FFFFFC, 1'b0);
    applyStimulus("overflow", 1'b0, 254, 28'h8000000, 1'b0);
    applyStimulus("tiny_exp1", 1'b0, 1, 28'h1000000, 1'b0);
    applyStimulus("tiny_negexp", 1'b1, -3, 28'h2345678, 1'b0);
    applyStimulus("long_norm", 1'b0, 200, 28'h0000008, 1'b0);

    // norm_start while busy must be ignored entirely.
    refModel(1'b0, 200, 28'h0000008, er, eo, eu, ei, el);
    @(negedge clk);
    bus.norm_start = 1'b1;
    bus.in_sign    = 1'b0;
    bus.in_exp     = 10'sd200;
    bus.in_mant    = 28'h0000008;
    @(posedge clk);
    @(negedge clk);
    bus.norm_start = 1'b0;
    n = 0;
    repeat (2) begin @(negedge clk); n++; end
    bus.norm_start = 1'b1;
    bus.in_sign    = 1'b1;
    bus.in_exp     = 10'sd127;
    bus.in_mant    = 28'h0;
    @(negedge clk);
    n++;
    bus.norm_start = 1'b0;
    waitDone(n, seen);
    checkOutput("busy_start.done_seen", {31'b0, seen}, 32'd1);
    checkOutput("busy_start.result", bus.norm_result, er);
    checkOutput("busy_start.latency", 32'(n), 32'(el));
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.norm_done === 1'b1) cnt++;
    end
    checkOutput("busy_start.no_extra_done", 32'(cnt), 32'd0);

    // Reset in the middle of normalization aborts without a done pulse.
    @(negedge clk);
    bus.norm_start = 1'b1;
    bus.in_sign    = 1'b1;
    bus.in_exp     = 10'sd200;
    bus.in_mant    = 28'h0000010;
    @(posedge clk);
    @(negedge clk);
    bus.norm_start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_busy", {31'b0, bus.norm_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_result", bus.norm_result, 32'd0);
    checkOutput("abort_outputs",
                {27'b0, bus.norm_done, bus.norm_busy, bus.norm_overflow,
                 bus.norm_underflow, bus.norm_inexact}, 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.norm_done === 1'b1) cnt++;
    end
    checkOutput("abort_no_done", 32'(cnt), 32'd0);
    applyStimulus("after_abort", 1'b0, 130, 28'h0C00000, 1'b0);

    // Random operands spread over normal, tiny, overflow and zero cases.
    for (int i = 0; i < 120; i++) begin
      s    = 1'(($urandom) & 1);
      e    = int'($urandom_range(0, 340)) - 40;
      nb   = int'($urandom_range(1, 28));
      mask = (28'h1 << nb) - 28'h1;
      m    = 28'($urandom) & mask;
      if ($urandom_range(0, 19) == 0) m = 28'h0;
      applyStimulus($sformatf("rand%0d", i), s, e, m, ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
